// File: rtl/debug_host_sequencer.sv
// Host-side byte sequencer for the UART debug link: streams a program, issues run/step/end, captures dumps.
// Optional DEBUG_HOST_CHECKSUM_EN adds a modulo-256 sum of the bytes received in each capture.
module debug_host_sequencer #(
  parameter int ROM_AW         = 8,
  parameter int CAP_AW         = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_step,
  input  logic              i_end_debug,
  output logic [ROM_AW-1:0] o_prog_addr,
  input  logic [31:0]       i_prog_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  input  logic              i_rx_done,
  input  logic [7:0]        i_rx_data,
  output logic              o_cap_we,
  output logic [CAP_AW-1:0] o_cap_addr,
  output logic [31:0]       o_cap_data,
  output logic [CAP_AW:0]   o_cap_count,
  output logic              o_cap_overflow,
  output logic              o_dump_done,
  output logic              o_busy,
  output logic [7:0]        o_checksum
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CAP_AW:0] CNT_MAX = {1'b1, {CAP_AW{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_OP, S_WORD, S_RUN, S_DBG_WAIT,
    S_STEP, S_END, S_CAPTURE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ROM_AW-1:0]   paddr_q, paddr_d;
  logic [1:0]          bidx_q, bidx_d;
  logic                wait_q, wait_d;
  logic [7:0]          txd_q, txd_d;
  logic                txs_q, txs_d;
  logic [1:0]          rxc_q, rxc_d;
  logic [31:0]         word_q, word_d;
  logic                got_q, got_d;
  logic [TW-1:0]       to_q, to_d;
  logic                we_q, we_d;
  logic [CAP_AW-1:0]   caddr_q, caddr_d;
  logic [31:0]         cdata_q, cdata_d;
  logic [CAP_AW:0]     ccnt_q, ccnt_d;
  logic                ovf_q, ovf_d;
  logic                dump_q, dump_d;

  logic                sent, sending, enter_cap;
  logic [7:0]          sbyte, wbyte;
  logic [31:0]         flush;

  assign sent = wait_q & i_tx_done;

  always_comb begin
    unique case (bidx_q)
      2'd0: wbyte = i_prog_data[31:24];
      2'd1: wbyte = i_prog_data[23:16];
      2'd2: wbyte = i_prog_data[15:8];
      2'd3: wbyte = i_prog_data[7:0];
    endcase
  end

  // Partial word is left-aligned: received bytes land in the MSBs.
  always_comb begin
    unique case (rxc_q)
      2'd1:    flush = {word_q[7:0], 24'h0};
      2'd2:    flush = {word_q[15:0], 16'h0};
      2'd3:    flush = {word_q[23:0], 8'h0};
      default: flush = word_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    paddr_d   = paddr_q;
    bidx_d    = bidx_q;
    wait_d    = wait_q;
    txd_d     = txd_q;
    txs_d     = 1'b0;
    rxc_d     = rxc_q;
    word_d    = word_q;
    got_d     = got_q;
    to_d      = to_q;
    we_d      = 1'b0;
    caddr_d   = caddr_q;
    cdata_d   = cdata_q;
    ccnt_d    = ccnt_q;
    ovf_d     = ovf_q;
    dump_d    = 1'b0;
    sending   = 1'b0;
    sbyte     = 8'h00;
    enter_cap = 1'b0;

    if (we_q) begin
      caddr_d = caddr_q + 1'b1;
      if (&caddr_q) ovf_d = 1'b1;
      if (ccnt_q != CNT_MAX) ccnt_d = ccnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mode_d  = i_mode;
          paddr_d = '0;
          bidx_d  = 2'd0;
          ovf_d   = 1'b0;
          state_d = S_LOAD_OP;
        end
      end
      S_LOAD_OP: begin
        sending = 1'b1;
        sbyte   = 8'h00;
        if (sent) state_d = S_WORD;
      end
      S_WORD: begin
        sending = 1'b1;
        sbyte   = wbyte;
        if (sent) begin
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == 2'd3) begin
            if (i_prog_data == 32'hFFFF_FFFF) state_d = S_RUN;
            else paddr_d = paddr_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        sending = 1'b1;
        sbyte   = mode_q ? 8'h02 : 8'h01;
        if (sent) begin
          if (mode_q) state_d = S_DBG_WAIT;
          else enter_cap = 1'b1;
        end
      end
      S_DBG_WAIT: begin
        if (i_step) state_d = S_STEP;
        else if (i_end_debug) state_d = S_END;
      end
      S_STEP: begin
        sending = 1'b1;
        sbyte   = 8'h03;
        if (sent) enter_cap = 1'b1;
      end
      S_END: begin
        sending = 1'b1;
        sbyte   = 8'h04;
        if (sent) state_d = S_IDLE;
      end
      S_CAPTURE: begin
        if (i_rx_done) begin
          got_d  = 1'b1;
          to_d   = '0;
          word_d = {word_q[23:0], i_rx_data};
          rxc_d  = rxc_q + 1'b1;
          if (rxc_q == 2'd3) begin
            we_d    = 1'b1;
            cdata_d = {word_q[23:0], i_rx_data};
          end
        end else if (got_q) begin
          if (to_q == TO_LAST) begin
            state_d = S_DONE;
            if (rxc_q != 2'd0) begin
              we_d    = 1'b1;
              cdata_d = flush;
            end
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        dump_d  = 1'b1;
        state_d = mode_q ? S_DBG_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_cap) begin
      state_d = S_CAPTURE;
      caddr_d = '0;
      ccnt_d  = '0;
      rxc_d   = 2'd0;
      word_d  = '0;
      got_d   = 1'b0;
      to_d    = '0;
    end

    // One start per byte, the next only after the previous done.
    if (sending) begin
      if (!wait_q) begin
        txs_d  = 1'b1;
        txd_d  = sbyte;
        wait_d = 1'b1;
      end else if (i_tx_done) begin
        wait_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      paddr_q <= '0;
      bidx_q  <= 2'd0;
      wait_q  <= 1'b0;
      txd_q   <= 8'h00;
      txs_q   <= 1'b0;
      rxc_q   <= 2'd0;
      word_q  <= '0;
      got_q   <= 1'b0;
      to_q    <= '0;
      we_q    <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
      ccnt_q  <= '0;
      ovf_q   <= 1'b0;
      dump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      paddr_q <= paddr_d;
      bidx_q  <= bidx_d;
      wait_q  <= wait_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
      rxc_q   <= rxc_d;
      word_q  <= word_d;
      got_q   <= got_d;
      to_q    <= to_d;
      we_q    <= we_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
      ccnt_q  <= ccnt_d;
      ovf_q   <= ovf_d;
      dump_q  <= dump_d;
    end
  end

`ifdef DEBUG_HOST_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || enter_cap) csum_q <= 8'h00;
    else if (state_q == S_CAPTURE && i_rx_done) csum_q <= csum_q + i_rx_data;
  end

  assign o_checksum = csum_q;
`else
  assign o_checksum = 8'h00;
`endif

  assign o_prog_addr    = paddr_q;
  assign o_tx_data      = txd_q;
  assign o_tx_start     = txs_q;
  assign o_cap_we       = we_q;
  assign o_cap_addr     = caddr_q;
  assign o_cap_data     = cdata_q;
  assign o_cap_count    = ccnt_q;
  assign o_cap_overflow = ovf_q;
  assign o_dump_done    = dump_q;
  assign o_busy         = (state_q != S_IDLE) && (state_q != S_DBG_WAIT);

endmodule

// File: tb/tb_debug_host_sequencer.sv
// Self-checking bench for debug_host_sequencer: table vectors, directed corner sequences
// and randomized sessions against a byte/word-level reference model.
module tb_debug_host_sequencer;

  localparam int ROM_AW = 4;
  localparam int CAP_AW = 2;
  localparam int TO     = 40;
  localparam int NWMAX  = 1 << CAP_AW;

  logic              clk = 1'b0;
  logic              rst, start, mode, step, endd;
  logic              tx_done, rx_done;
  logic [7:0]        rx_data;
  logic [ROM_AW-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              cap_we;
  logic [CAP_AW-1:0] cap_addr;
  logic [31:0]       cap_data;
  logic [CAP_AW:0]   cap_count;
  logic              cap_ovf, dump_done, busy;
  logic [7:0]        checksum;

  debug_host_sequencer #(
    .ROM_AW(ROM_AW), .CAP_AW(CAP_AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
    .i_step(step), .i_end_debug(endd),
    .o_prog_addr(prog_addr), .i_prog_data(prog_data),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_cap_we(cap_we), .o_cap_addr(cap_addr), .o_cap_data(cap_data),
    .o_cap_count(cap_count), .o_cap_overflow(cap_ovf),
    .o_dump_done(dump_done), .o_busy(busy), .o_checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [16];
  assign prog_data = rom[prog_addr];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // uart_tx stand-in: records bytes, answers done tx_lat cycles later
  logic [7:0] got_tx[$];
  bit         pend = 1'b0;
  int         dly = 0;
  int         tx_lat = 10;

  always @(negedge clk) begin
    if (rst) begin
      pend    = 1'b0;
      tx_done = 1'b0;
    end else if (tx_start) begin
      chk("tx_start_gap", {31'b0, pend}, 32'd0);
      got_tx.push_back(tx_data);
      pend    = 1'b1;
      dly     = tx_lat;
      tx_done = 1'b0;
    end else if (tx_done) begin
      tx_done = 1'b0;
      pend    = 1'b0;
    end else if (pend) begin
      dly--;
      if (dly <= 0) tx_done = 1'b1;
    end
  end

  logic [31:0] wr_data[$];
  int          wr_addr[$];

  always @(negedge clk) begin
    if (!rst && cap_we) begin
      wr_data.push_back(cap_data);
      wr_addr.push_back(int'(cap_addr));
    end
  end

  logic [31:0] prog_q[$];
  logic [7:0]  byte_q[$];
  bit          ovf_m;
  logic [CAP_AW:0] d_cnt;
  logic        d_ovf;
  logic [7:0]  d_csum;

  typedef struct packed {
    logic [3:0]  n;
    logic [63:0] bytes;
    logic [1:0]  nw;
    logic [63:0] words;
    logic [2:0]  cnt;
    logic [7:0]  cs;
  } vec_t;

  vec_t tbl[4];

  task automatic wr_clear();
    wr_data.delete();
    wr_addr.delete();
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while (got_tx.size() < n && t < 8000) begin tick(); t++; end
    t = 0;
    while (pend && t < 100) begin tick(); t++; end
    tick(3);
    chk("tx_count", got_tx.size(), n);
  endtask

  task automatic start_prog(input bit m);
    logic [7:0] exp[$];
    for (int i = 0; i < 16; i++)
      rom[i] = (i < prog_q.size()) ? prog_q[i] : 32'h0BAD_0000 + i;
    exp.push_back(8'h00);
    foreach (prog_q[i])
      for (int k = 3; k >= 0; k--) exp.push_back(prog_q[i][8*k +: 8]);
    exp.push_back(m ? 8'h02 : 8'h01);
    got_tx.delete();
    ovf_m = 1'b0;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = ~m;
    wait_tx(exp.size());
    foreach (exp[i])
      chk($sformatf("tx_byte%0d", i),
          (i < got_tx.size()) ? 32'(got_tx[i]) : 32'hDEAD, exp[i]);
    chk("ovf_clear_on_start", {31'b0, cap_ovf}, 32'd0);
  endtask

  task automatic send_cmd(input bit st, input bit en, input logic [7:0] b);
    got_tx.delete();
    step = st;
    endd = en;
    tick();
    step = 1'b0;
    endd = 1'b0;
    wait_tx(1);
    chk("cmd_byte", (got_tx.size() > 0) ? 32'(got_tx[0]) : 32'hDEAD, b);
  endtask

  task automatic do_capture(input int gapmax, input bit poke);
    int t;
    int extra;
    foreach (byte_q[i]) begin
      tick($urandom_range(gapmax, 0));
      rx_data = byte_q[i];
      rx_done = 1'b1;
      if (poke && i == 1) start = 1'b1;
      tick();
      rx_done = 1'b0;
      start   = 1'b0;
      rx_data = 8'($urandom);
    end
    t = 0;
    while (!dump_done && t < TO + 30) begin tick(); t++; end
    chk("dump_latency_ok", {31'b0, (t >= TO && t <= TO + 4)}, 32'd1);
    d_cnt  = cap_count;
    d_ovf  = cap_ovf;
    d_csum = checksum;
    extra  = 0;
    repeat (3) begin tick(); extra += int'(dump_done); end
    chk("dump_single_pulse", extra, 0);
  endtask

  task automatic check_model();
    int nb, nw, s;
    logic [31:0] w;
    nb = byte_q.size();
    nw = (nb + 3) / 4;
    s  = 0;
    chk("model_nwrites", wr_data.size(), nw);
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++)
        w = {w[23:0], (4*i + k < nb) ? byte_q[4*i + k] : 8'h00};
      chk($sformatf("model_wdata%0d", i),
          (i < wr_data.size()) ? wr_data[i] : 32'hDEAD, w);
      chk($sformatf("model_waddr%0d", i),
          (i < wr_addr.size()) ? wr_addr[i] : -1, i % NWMAX);
    end
    foreach (byte_q[i]) s += byte_q[i];
    if (nw >= NWMAX) ovf_m = 1'b1;
    chk("model_count", d_cnt, (nw > NWMAX) ? NWMAX : nw);
    chk("model_overflow", {31'b0, d_ovf}, {31'b0, ovf_m});
`ifdef DEBUG_HOST_CHECKSUM_EN
    chk("model_checksum", d_csum, s & 255);
`else
    chk("model_checksum", d_csum, 0);
`endif
  endtask

  task automatic idle_no_tx();
    got_tx.delete();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(40);
    chk("idle_ignores_step", got_tx.size(), 0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_prog_addr"}, prog_addr, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_cap_we"}, cap_we, 0);
    chk({tag, "_cap_addr"}, cap_addr, 0);
    chk({tag, "_cap_data"}, cap_data, 0);
    chk({tag, "_cap_count"}, cap_count, 0);
    chk({tag, "_ovf"}, cap_ovf, 0);
    chk({tag, "_dump"}, dump_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  task automatic std_prog();
    prog_q.delete();
    prog_q.push_back(32'h2001_0005);
    prog_q.push_back(32'hFFFF_FFFF);
  endtask

  initial begin
    int t, nd;
    bit m;
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; mode = 1'b0; step = 1'b0; endd = 1'b0;
    rx_done = 1'b0; rx_data = 8'h00; tx_done = 1'b0;

    tbl[0] = '{4'd8, 64'h1122334455667788, 2'd2,
               64'h1122334455667788, 3'd2, 8'h64};
    tbl[1] = '{4'd5, 64'hAABBCCDDEE000000, 2'd2,
               64'hAABBCCDDEE000000, 3'd2, 8'hFC};
    tbl[2] = '{4'd1, 64'h5A00000000000000, 2'd1,
               64'h5A00000000000000, 3'd1, 8'h5A};
    tbl[3] = '{4'd3, 64'h0102030000000000, 2'd1,
               64'h0102030000000000, 3'd1, 8'h06};

    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(2);
    check_zero("after_reset");

    // table vectors: continuous mode, fixed program
    for (int v = 0; v < 4; v++) begin
      std_prog();
      wr_clear();
      tx_lat = 10;
      start_prog(1'b0);
      byte_q.delete();
      for (int i = 0; i < int'(tbl[v].n); i++)
        byte_q.push_back(tbl[v].bytes[63 - 8*i -: 8]);
      do_capture(3, 1'b0);
      chk($sformatf("v%0d_nwrites", v), wr_data.size(), tbl[v].nw);
      for (int i = 0; i < int'(tbl[v].nw); i++) begin
        chk($sformatf("v%0d_wdata%0d", v, i),
            (i < wr_data.size()) ? wr_data[i] : 32'hDEAD,
            tbl[v].words[63 - 32*i -: 32]);
        chk($sformatf("v%0d_waddr%0d", v, i),
            (i < wr_addr.size()) ? wr_addr[i] : -1, i);
      end
      chk($sformatf("v%0d_count", v), d_cnt, tbl[v].cnt);
`ifdef DEBUG_HOST_CHECKSUM_EN
      chk($sformatf("v%0d_checksum", v), d_csum, tbl[v].cs);
`else
      chk($sformatf("v%0d_checksum", v), d_csum, 0);
`endif
      idle_no_tx();
    end

    // debug mode: step, silence before first byte, step+end together, end
    std_prog();
    tx_lat = 6;
    start_prog(1'b1);
    chk("dbg_wait_busy", {31'b0, busy}, 32'd0);
    send_cmd(1'b1, 1'b0, 8'h03);
    nd = 0;
    repeat (2 * TO) begin tick(); nd += int'(dump_done); end
    chk("no_dump_before_first_byte", nd, 0);
    chk("capture_busy", {31'b0, busy}, 32'd1);
    wr_clear();
    byte_q.delete();
    byte_q.push_back(8'hDE); byte_q.push_back(8'hAD);
    byte_q.push_back(8'hBE); byte_q.push_back(8'hEF);
    do_capture(2, 1'b0);
    chk("dbg_word", (wr_data.size() > 0) ? wr_data[0] : 32'hDEAD, 32'hDEADBEEF);
    chk("dbg_count", d_cnt, 1);
    chk("dbg_back_wait", {31'b0, busy}, 32'd0);
    send_cmd(1'b1, 1'b1, 8'h03);
    chk("step_wins_capture", {31'b0, busy}, 32'd1);
    wr_clear();
    byte_q.delete();
    byte_q.push_back(8'h12); byte_q.push_back(8'h34);
    do_capture(2, 1'b0);
    chk("dbg_partial", (wr_data.size() > 0) ? wr_data[0] : 32'hDEAD, 32'h12340000);
    send_cmd(1'b0, 1'b1, 8'h04);
    idle_no_tx();

    // address wrap, overflow and count saturation
    std_prog();
    tx_lat = 3;
    wr_clear();
    start_prog(1'b0);
    byte_q.delete();
    for (int i = 0; i < 18; i++) byte_q.push_back(8'(i + 1));
    do_capture(1, 1'b0);
    check_model();
    chk("ovf_set", {31'b0, cap_ovf}, 32'd1);
    start_prog(1'b0);
    byte_q.delete();
    byte_q.push_back(8'h77);
    wr_clear();
    do_capture(1, 1'b0);
    check_model();

    // reset mid-word, then a clean restart from the load opcode
    prog_q.delete();
    prog_q.push_back(32'h1111_1111);
    prog_q.push_back(32'h2001_0705);
    prog_q.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++)
      rom[i] = (i < prog_q.size()) ? prog_q[i] : 32'h0;
    tx_lat = 10;
    got_tx.delete();
    mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (got_tx.size() < 8 && t < 2000) begin tick(); t++; end
    chk("pre_reset_tx", got_tx.size(), 8);
    tick(2);
    rst = 1'b1;
    tick();
    check_zero("midreset");
    rst = 1'b0;
    tick(2);
    wr_clear();
    start_prog(1'b0);
    byte_q.delete();
    byte_q.push_back(8'hC3);
    do_capture(1, 1'b0);
    check_model();

    // randomized sessions against the model
    for (int s = 0; s < 12; s++) begin
      int nw, nb, reps;
      nw = $urandom_range(4, 0);
      prog_q.delete();
      for (int j = 0; j < nw; j++) begin
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        prog_q.push_back(w);
      end
      prog_q.push_back(32'hFFFF_FFFF);
      tx_lat = $urandom_range(15, 1);
      m = 1'($urandom_range(1, 0));
      wr_clear();
      start_prog(m);
      reps = m ? $urandom_range(2, 1) : 1;
      for (int r = 0; r < reps; r++) begin
        if (m) send_cmd(1'b1, 1'($urandom_range(1, 0)), 8'h03);
        nb = $urandom_range(18, 1);
        byte_q.delete();
        for (int j = 0; j < nb; j++) byte_q.push_back(8'($urandom));
        wr_clear();
        do_capture(TO / 2, 1'($urandom_range(1, 0)));
        check_model();
      end
      if (m) send_cmd(1'b0, 1'b1, 8'h04);
      idle_no_tx();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/debug_host_sequencer.md
Name: debug_host_sequencer

Overview:
- Host-side peer of the UART debug interface, at the byte level.
- Streams a program to the target:
  - load opcode first, then 32-bit words MSB-first, up to and including the HALT word.
  - then issues the run command (continuous or debug); in debug mode, issues step/end commands.
- Captures the returned dump bytes into 32-bit words for a capture buffer.
- Placement: bench/loopback top, between a program ROM, a uart_tx/uart_rx pair and a capture RAM.

Parameters:
- ROM_AW, 8, program ROM word-address width.
- CAP_AW, 8, capture buffer word-address width.
- TIMEOUT_CYCLES, 100000, idle cycles after the last received byte that end a dump.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_start  in  1  pulse: begin load + run
- i_mode  in  1  sampled with i_start: 0 continuous, 1 debug
- i_step  in  1  pulse: send STEP (debug only)
- i_end_debug  in  1  pulse: send END_DEBUG (debug only)
- o_prog_addr  out  ROM_AW  program ROM word address
- i_prog_data  in  32  ROM word at o_prog_addr, combinational, valid same cycle
- o_tx_data  out  8  byte to uart_tx
- o_tx_start  out  1  one-cycle send strobe
- i_tx_done  in  1  uart_tx finished current byte
- i_rx_done  in  1  uart_rx byte-valid strobe
- i_rx_data  in  8  received byte
- o_cap_we  out  1  capture word write strobe
- o_cap_addr  out  CAP_AW  capture word address
- o_cap_data  out  32  assembled word
- o_cap_count  out  CAP_AW+1  words written in current dump
- o_cap_overflow  out  1  sticky: capture address wrapped
- o_dump_done  out  1  one-cycle pulse at dump end
- o_busy  out  1  high in every state except IDLE and DEBUG_WAIT
- o_checksum  out  8  see Optional Feature

Behaviour:
- Opcodes: LOAD 0x00, START_CONT 0x01, START_DEBUG 0x02, STEP 0x03, END_DEBUG 0x04. HALT word = 0xFFFFFFFF.
- Reset values: all outputs 0; state IDLE; byte and timeout counters 0.
- Byte send rule:
  - o_tx_start is a 1-cycle pulse, with o_tx_data registered in the same cycle.
  - The next o_tx_start is issued no earlier than the cycle after i_tx_done is seen.
  - Never two starts without an intervening i_tx_done.
- States:
  - IDLE: on i_start, latch i_mode, o_prog_addr=0, go to SEND_LOAD_OP. Any other input is ignored.
  - SEND_LOAD_OP: send 0x00, then go to SEND_WORD.
  - SEND_WORD: send i_prog_data bytes [31:24], [23:16], [15:8], [7:0] in that order.
    - After the 4th byte: if the word was 0xFFFFFFFF, go to SEND_RUN.
    - Otherwise increment o_prog_addr (wraps at 2^ROM_AW) and repeat.
  - SEND_RUN: send 0x01 (mode 0) or 0x02 (mode 1).
    - Mode 0: go to CAPTURE.
    - Mode 1: go to DEBUG_WAIT.
  - DEBUG_WAIT: on i_step, send 0x03 and go to CAPTURE; on i_end_debug, send 0x04 and go to IDLE. i_step and i_end_debug in the same cycle: step wins, end is dropped.
  - CAPTURE:
    - Reset o_cap_addr and o_cap_count at entry.
    - Each i_rx_done shifts the byte into the word MSB-first.
    - On the 4th byte, pulse o_cap_we with the word at o_cap_addr, then increment the address.
    - The timeout counter starts only after the first byte and clears on every byte.
    - When it reaches TIMEOUT_CYCLES, flush any partial word left-aligned, zero-padded (received bytes occupy the MSBs). Then pulse o_dump_done and go to DEBUG_WAIT (mode 1) or IDLE (mode 0).
    - Before the first byte, wait indefinitely.
- o_cap_addr wraps at 2^CAP_AW; o_cap_overflow is set on the wrap and cleared only by reset or a new i_start.
- o_cap_count saturates at 2^CAP_AW.
- i_rx_done outside CAPTURE: ignored. i_start while not IDLE: ignored.
- Reset mid-operation: the in-flight byte is abandoned and all state returns to reset values next cycle.

Optional Feature:
- DEBUG_HOST_CHECKSUM_EN defined:
  - o_checksum is the 8-bit modulo-256 sum of all bytes received in the current CAPTURE.
  - It clears at CAPTURE entry and is held after o_dump_done.
- Undefined: o_checksum tied to 0 and no adder is synthesized.

Test Plan:
- ROM = {0x20010005, 0xFFFFFFFF}, i_mode=0, i_start, tx_done returned 10 cycles after each start -> tx bytes 00,20,01,00,05,FF,FF,FF,FF,01 in order, never a start before the preceding tx_done.
- In CAPTURE: rx bytes 11,22,33,44,55,66,77,88, then silence for TIMEOUT_CYCLES -> writes 0x11223344@0 and 0x55667788@1, then o_dump_done, o_cap_count=2, return to IDLE; with DEBUG_HOST_CHECKSUM_EN, o_checksum=0x64.
- Partial word: rx AA,BB,CC,DD,EE, then timeout -> writes 0xAABBCCDD@0 and 0xEE000000@1, count=2.
- Debug mode: i_mode=1 -> run byte 02, DEBUG_WAIT. i_step -> 03, capture 4 bytes, timeout, back to DEBUG_WAIT. i_end_debug -> 04, IDLE.
- In DEBUG_WAIT, i_step and i_end_debug in the same cycle -> only 03 sent, state CAPTURE.
- Assert i_reset after the 3rd byte of a word -> next cycle all outputs 0 and state IDLE; a new i_start restarts from 00.
